// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: mode-filtered, optionally PC-triggered capture of retire records
// into a FIFO drained over valid/ready. Pure observer: it never back-pressures the core.
`default_nettype none

module retire_trace_buffer #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 16,
   parameter bit STOP_ON_FULL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ret_valid,
   input  logic [XLEN-1:0]          ret_pc,
   input  logic [31:0]              ret_instr,
   input  logic [4:0]               ret_rd,
   input  logic [XLEN-1:0]          ret_result,
   input  logic                     ret_regwrite,
   input  logic                     ret_memwrite,
   input  logic [XLEN-1:0]          ret_mem_addr,
   input  logic [XLEN-1:0]          ret_mem_wdata,
   input  logic [1:0]               mode,
   input  logic                     arm,
   input  logic                     trig_en,
   input  logic [XLEN-1:0]          trig_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [XLEN-1:0]          out_data,
   output logic [XLEN-1:0]          out_addr,
   output logic [4:0]               out_rd,
   output logic [1:0]               out_kind,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drop_cnt,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3*XLEN + 32 + 5 + 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_CAPTURE = 2'b10,
      S_FROZEN  = 2'b11
   } state_t;

   state_t          state_q;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     level_q;
   logic [15:0]     drop_q;
   logic [XLEN-1:0] prev_pc_q;
   logic            prev_pc_valid_q;

   logic            cflow, mode_hit, trig_hit, eligible, full, pop, push, drop;
   logic [1:0]      kind;
   logic [EW-1:0]   rec, head;

   always_comb begin
      cflow = prev_pc_valid_q && (ret_pc != prev_pc_q + XLEN'(4));
      case (mode)
         2'b00:   mode_hit = 1'b1;
         2'b01:   mode_hit = ret_regwrite && (ret_rd != 5'd0);
         2'b10:   mode_hit = ret_memwrite;
         default: mode_hit = cflow;
      endcase
      // The record that matches the trigger PC is itself a capture candidate.
      trig_hit = (state_q == S_ARMED) && ret_valid && (ret_pc == trig_pc);
      eligible = ret_valid && !arm && mode_hit && ((state_q == S_CAPTURE) || trig_hit);
      full     = (level_q == (AW+1)'(DEPTH));
      pop      = out_valid && out_ready;
      push     = eligible && (!full || pop);
      drop     = eligible && full && !pop && !STOP_ON_FULL;
      if (ret_memwrite)      kind = 2'b01;
      else if (cflow)        kind = 2'b10;
      else if (ret_regwrite) kind = 2'b00;
      else                   kind = 2'b11;
      rec  = {ret_pc, ret_instr,
              ret_memwrite ? ret_mem_wdata : ret_result,
              ret_memwrite ? ret_mem_addr  : {XLEN{1'b0}},
              ret_rd, kind};
      head = out_valid ? mem_q[rd_ptr_q] : {EW{1'b0}};
   end

   assign out_valid = (level_q != '0);
   assign {out_pc, out_instr, out_data, out_addr, out_rd, out_kind} = head;
   assign level     = level_q;
   assign drop_cnt  = drop_q;
   assign state     = state_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         level_q         <= '0;
         drop_q          <= '0;
         prev_pc_q       <= '0;
         prev_pc_valid_q <= 1'b0;
      end else begin
         if (ret_valid) begin
            prev_pc_q       <= ret_pc;
            prev_pc_valid_q <= 1'b1;
         end
         if (arm) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            state_q  <= trig_en ? S_ARMED : S_CAPTURE;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            case (state_q)
               S_ARMED:   if (trig_hit) state_q <= S_CAPTURE;
               S_CAPTURE: if (full && STOP_ON_FULL) state_q <= S_FROZEN;
               default:   state_q <= state_q;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two instances (STOP_ON_FULL=1 and 0) against a queue model.
`default_nettype none

module tb_retire_trace_buffer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ret_valid = 1'b0, ret_regwrite = 1'b0, ret_memwrite = 1'b0;
   logic [31:0] ret_pc = '0, ret_instr = '0, ret_result = '0, ret_mem_addr = '0, ret_mem_wdata = '0;
   logic [4:0]  ret_rd = '0;
   logic [1:0]  mode = '0;
   logic        arm = 1'b0, trig_en = 1'b0, out_ready = 1'b0;
   logic [31:0] trig_pc = '0;

   logic        ov [2];
   logic [31:0] opc [2], oinstr [2], odata [2], oaddr [2];
   logic [4:0]  ord [2];
   logic [1:0]  okind [2];
   logic [4:0]  olevel [2];
   logic [15:0] odrop [2];
   logic [1:0]  ostate [2];

   always #5 clk = ~clk;

   retire_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) u_sof (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
      .ret_rd(ret_rd), .ret_result(ret_result), .ret_regwrite(ret_regwrite),
      .ret_memwrite(ret_memwrite), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
      .mode(mode), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_instr(oinstr[0]),
      .out_data(odata[0]), .out_addr(oaddr[0]), .out_rd(ord[0]), .out_kind(okind[0]),
      .level(olevel[0]), .drop_cnt(odrop[0]), .state(ostate[0]));

   retire_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) u_drop (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
      .ret_rd(ret_rd), .ret_result(ret_result), .ret_regwrite(ret_regwrite),
      .ret_memwrite(ret_memwrite), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
      .mode(mode), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_instr(oinstr[1]),
      .out_data(odata[1]), .out_addr(oaddr[1]), .out_rd(ord[1]), .out_kind(okind[1]),
      .level(olevel[1]), .drop_cnt(odrop[1]), .state(ostate[1]));

   typedef struct packed {
      logic [31:0] pc, instr, data, addr;
      logic [4:0]  rd;
      logic [1:0]  kind;
   } rec_t;

   int   n_total = 0, n_pass = 0, maxlvl = 0;
   rec_t mq [2][$];
   rec_t plog [2][$];
   int   mst [2];
   int   mdrop [2];
   logic [31:0] mprev = '0;
   bit   mprev_v = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: one queue per instance, advanced on every clock edge.
   bit   m_cf, m_match, m_pop, m_full, m_hit, m_elig;
   int   m_nst;
   rec_t m_r;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mst[i]   = 0;
            mdrop[i] = 0;
         end
         mprev   = '0;
         mprev_v = 1'b0;
      end else begin
         m_cf = mprev_v && (ret_pc != mprev + 32'd4);
         case (mode)
            2'd0: m_match = 1'b1;
            2'd1: m_match = ret_regwrite && (ret_rd != 0);
            2'd2: m_match = ret_memwrite;
            default: m_match = m_cf;
         endcase
         m_r.pc    = ret_pc;
         m_r.instr = ret_instr;
         m_r.data  = ret_memwrite ? ret_mem_wdata : ret_result;
         m_r.addr  = ret_memwrite ? ret_mem_addr : 32'd0;
         m_r.rd    = ret_rd;
         m_r.kind  = ret_memwrite ? 2'd1 : m_cf ? 2'd2 : ret_regwrite ? 2'd0 : 2'd3;
         for (int i = 0; i < 2; i++) begin
            m_pop = (mq[i].size() > 0) && out_ready;
            if (arm) begin
               mq[i].delete();
               mdrop[i] = 0;
               mst[i]   = trig_en ? 1 : 2;
            end else begin
               m_hit  = (mst[i] == 1) && ret_valid && (ret_pc == trig_pc);
               m_elig = ret_valid && m_match && ((mst[i] == 2) || m_hit);
               m_full = (mq[i].size() == DEPTH);
               if (m_hit) m_nst = 2;
               else if ((mst[i] == 2) && m_full && (i == 0)) m_nst = 3;
               else m_nst = mst[i];
               if (m_pop) void'(mq[i].pop_front());
               if (m_elig) begin
                  if (!m_full || m_pop) mq[i].push_back(m_r);
                  else if ((i == 1) && (mdrop[i] < 65535)) mdrop[i]++;
               end
               mst[i] = m_nst;
            end
         end
         if (ret_valid) begin
            mprev   = ret_pc;
            mprev_v = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d.state", i), 64'(ostate[i]), 64'(mst[i]));
         chk($sformatf("u%0d.level", i), 64'(olevel[i]), 64'(mq[i].size()));
         chk($sformatf("u%0d.drop", i), 64'(odrop[i]), 64'(mdrop[i]));
         chk($sformatf("u%0d.valid", i), 64'(ov[i]), 64'(mq[i].size() > 0));
         if (mq[i].size() > 0) begin
            chk($sformatf("u%0d.pc", i), 64'(opc[i]), 64'(mq[i][0].pc));
            chk($sformatf("u%0d.instr", i), 64'(oinstr[i]), 64'(mq[i][0].instr));
            chk($sformatf("u%0d.data", i), 64'(odata[i]), 64'(mq[i][0].data));
            chk($sformatf("u%0d.addr", i), 64'(oaddr[i]), 64'(mq[i][0].addr));
            chk($sformatf("u%0d.rdkind", i), 64'({ord[i], okind[i]}),
                64'({mq[i][0].rd, mq[i][0].kind}));
         end
         if (ov[i] && out_ready && !reset)
            plog[i].push_back({opc[i], oinstr[i], odata[i], oaddr[i], ord[i], okind[i]});
      end
      if (int'(olevel[0]) > maxlvl) maxlvl = int'(olevel[0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic start(input logic [1:0] m, input logic te, input logic [31:0] tp);
      mode = m; trig_en = te; trig_pc = tp; arm = 1'b1;
      tick();
      arm = 1'b0;
      plog[0].delete(); plog[1].delete();
      maxlvl = 0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [4:0] rd, input logic rw, input logic mw);
      ret_valid = 1'b1; ret_pc = pc; ret_rd = rd; ret_regwrite = rw; ret_memwrite = mw;
      ret_instr = $urandom; ret_result = $urandom; ret_mem_addr = $urandom; ret_mem_wdata = $urandom;
      tick();
   endtask

   task automatic idle(input int n);
      ret_valid = 1'b0;
      repeat (n) tick();
   endtask

   logic [31:0] cur_pc;

   initial begin
      repeat (2) tick();
      do_reset();
      chk("reset.state", 64'(ostate[0]), 64'd0);
      chk("reset.level", 64'(olevel[0]), 64'd0);
      chk("reset.pc", 64'(opc[0]), 64'd0);

      // Sequential capture, all records, consumer always ready.
      out_ready = 1'b1;
      start(2'b00, 1'b0, 32'd0);
      for (int k = 0; k < 5; k++) retire(32'(k*4), 5'd1, 1'b1, 1'b0);
      idle(3);
      chk("t1.count", 64'(plog[0].size()), 64'd5);
      for (int k = 0; k < 5 && k < plog[0].size(); k++) chk("t1.pc", 64'(plog[0][k].pc), 64'(k*4));
      chk("t1.maxlvl", 64'(maxlvl), 64'd1);

      // Regwrite filter: rd=0 records are skipped.
      do_reset();
      start(2'b01, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) retire(32'(k*4), (k % 2 == 0) ? 5'd0 : 5'd5, 1'b1, 1'b0);
      idle(3);
      chk("t2.count", 64'(plog[0].size()), 64'd4);
      for (int k = 0; k < plog[0].size(); k++) chk("t2.rdkind", 64'({plog[0][k].rd, plog[0][k].kind}), 64'({5'd5, 2'b00}));

      // PC trigger.
      do_reset();
      start(2'b00, 1'b1, 32'h20);
      for (int k = 0; k < 8; k++) retire(32'(k*4), 5'd1, 1'b1, 1'b0);
      chk("t3.armed", 64'(ostate[0]), 64'd1);
      for (int k = 8; k < 13; k++) retire(32'(k*4), 5'd1, 1'b1, 1'b0);
      idle(3);
      chk("t3.capture", 64'(ostate[0]), 64'd2);
      chk("t3.count", 64'(plog[0].size()), 64'd5);
      for (int k = 0; k < 5 && k < plog[0].size(); k++) chk("t3.pc", 64'(plog[0][k].pc), 64'(32'h20 + k*4));

      // Control-flow filter.
      do_reset();
      start(2'b11, 1'b0, 32'd0);
      retire(32'h0, 5'd1, 1'b1, 1'b0); retire(32'h4, 5'd1, 1'b1, 1'b0);
      retire(32'h40, 5'd1, 1'b1, 1'b0); retire(32'h44, 5'd1, 1'b1, 1'b0);
      retire(32'h8, 5'd1, 1'b1, 1'b0);
      idle(3);
      chk("t4.count", 64'(plog[0].size()), 64'd2);
      if (plog[0].size() == 2) begin
         chk("t4.pc0", 64'(plog[0][0].pc), 64'h40);
         chk("t4.pc1", 64'(plog[0][1].pc), 64'h8);
         chk("t4.kind", 64'(plog[0][1].kind), 64'd2);
      end

      // Overflow: drop vs freeze.
      do_reset();
      out_ready = 1'b0;
      start(2'b00, 1'b0, 32'd0);
      for (int k = 0; k < 20; k++) retire(32'(k*4), 5'd1, 1'b1, 1'b0);
      idle(2);
      chk("t5.lvl1", 64'(olevel[1]), 64'd16);
      chk("t5.drop1", 64'(odrop[1]), 64'd4);
      chk("t5.state1", 64'(ostate[1]), 64'd2);
      chk("t5.lvl0", 64'(olevel[0]), 64'd16);
      chk("t5.drop0", 64'(odrop[0]), 64'd0);
      chk("t5.state0", 64'(ostate[0]), 64'd3);
      out_ready = 1'b1;
      idle(20);
      chk("t5.count", 64'(plog[1].size()), 64'd16);
      for (int k = 0; k < plog[1].size(); k++) chk("t5.pc", 64'(plog[1][k].pc), 64'(k*4));

      // Asynchronous reset in the middle of a drain.
      out_ready = 1'b0;
      start(2'b00, 1'b0, 32'd0);
      for (int k = 0; k < 10; k++) retire(32'(k*4), 5'd1, 1'b1, 1'b0);
      out_ready = 1'b1;
      idle(2);
      #2 reset = 1'b1;
      #1;
      chk("t6.valid", 64'(ov[0]), 64'd0);
      chk("t6.level", 64'(olevel[0]), 64'd0);
      chk("t6.state", 64'(ostate[0]), 64'd0);
      reset = 1'b0;
      tick();

      // Randomized traffic.
      cur_pc = 32'd0;
      start(2'b00, 1'b0, 32'd0);
      for (int c = 0; c < 4000; c++) begin
         ret_valid = ($urandom % 4) != 0;
         cur_pc = (($urandom % 5) == 0) ? 32'($urandom_range(0, 63) * 4) : cur_pc + 32'd4;
         ret_pc = cur_pc;
         ret_rd = 5'($urandom_range(0, 7));
         ret_regwrite = $urandom % 2; ret_memwrite = ($urandom % 4) == 0;
         ret_instr = $urandom; ret_result = $urandom; ret_mem_addr = $urandom; ret_mem_wdata = $urandom;
         if (($urandom % 50) == 0) mode = 2'($urandom);
         arm = ($urandom % 60) == 0;
         if (arm) begin
            trig_en = $urandom % 2;
            trig_pc = 32'($urandom_range(0, 63) * 4);
         end
         if (($urandom % 8) == 0) out_ready = ($urandom % 3) != 0;
         if (($urandom % 1000) == 0) begin
            reset = 1'b1;
            #1 reset = 1'b0;
         end
         tick();
      end
      arm = 1'b0;
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
